program_loader: RTL and testbench

//   Byte-stream writer for instruction memory: receives a framed program image from the

---
 rtl/program_loader.sv | 203 ++++++++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: unpacks a SYNC/LEN/DATA byte frame into instruction-memory write strobes.
// Define CHECKSUM_EN to require a trailing XOR-of-data byte before a frame counts as loaded.
module program_loader #(
   parameter int         NB_INSTRUCTION = 16,
   parameter int         NB_ADDR        = 10,
   parameter int         ROM_DEPTH      = 2**NB_ADDR,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic [7:0]                i_rx_data,
   input  logic                      i_rx_valid,
   output logic                      o_wr_en,
   output logic [NB_ADDR-1:0]        o_wr_addr,
   output logic [NB_INSTRUCTION-1:0] o_wr_data,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_loaded,
   output logic                      o_error
);
   localparam int BPW     = NB_INSTRUCTION / 8;
   localparam int NB_BCNT = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int NB_WCNT = NB_ADDR + 1;
   localparam int NB_SH   = (BPW > 1) ? NB_INSTRUCTION - 8 : 1;

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK, ST_ERR} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_ERR} state_t;
`endif

   state_t                    r_state,   w_state_next;
   logic [15:0]               r_len,     w_len_next;
   logic [NB_BCNT-1:0]        r_bcnt,    w_bcnt_next;
   logic [NB_WCNT-1:0]        r_wcnt,    w_wcnt_next;
   logic [NB_SH-1:0]          r_shift,   w_shift_next;
   logic                      r_wr_en,   w_wr_en_next;
   logic [NB_ADDR-1:0]        r_wr_addr, w_wr_addr_next;
   logic [NB_INSTRUCTION-1:0] r_wr_data, w_wr_data_next;
   logic                      r_done,    w_done_next;
   logic                      r_loaded,  w_loaded_next;
   logic                      r_error,   w_error_next;
`ifdef CHECKSUM_EN
   logic [7:0]                r_csum,    w_csum_next;
`endif

   logic [NB_INSTRUCTION-1:0] w_word;
   logic [NB_SH-1:0]          w_shift_in;
   logic [15:0]               w_len_full;
   logic                      w_len_bad;
   logic                      w_last_word;
   logic                      w_sync;

   // The partial word keeps the BPW-1 oldest bytes; the incoming byte completes it (MSB first).
   generate
      if (BPW > 1) begin : g_multi
         assign w_word     = {r_shift, i_rx_data};
         assign w_shift_in = w_word[NB_SH-1:0];
      end else begin : g_single
         assign w_word     = i_rx_data;
         assign w_shift_in = '0;
      end
   endgenerate

   assign w_sync      = i_rx_valid && (i_rx_data == SYNC_BYTE);
   assign w_len_full  = {r_len[15:8], i_rx_data};
   assign w_len_bad   = (w_len_full == 16'd0) || ({16'd0, w_len_full} > ROM_DEPTH);
   assign w_last_word = ({{(32-NB_WCNT){1'b0}}, r_wcnt} + 32'd1) == {16'd0, r_len};

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= ST_IDLE;
         r_len     <= '0;
         r_bcnt    <= '0;
         r_wcnt    <= '0;
         r_shift   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_done    <= 1'b0;
         r_loaded  <= 1'b0;
         r_error   <= 1'b0;
`ifdef CHECKSUM_EN
         r_csum    <= '0;
`endif
      end else begin
         r_state   <= w_state_next;
         r_len     <= w_len_next;
         r_bcnt    <= w_bcnt_next;
         r_wcnt    <= w_wcnt_next;
         r_shift   <= w_shift_next;
         r_wr_en   <= w_wr_en_next;
         r_wr_addr <= w_wr_addr_next;
         r_wr_data <= w_wr_data_next;
         r_done    <= w_done_next;
         r_loaded  <= w_loaded_next;
         r_error   <= w_error_next;
`ifdef CHECKSUM_EN
         r_csum    <= w_csum_next;
`endif
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_len_next     = r_len;
      w_bcnt_next    = r_bcnt;
      w_wcnt_next    = r_wcnt;
      w_shift_next   = r_shift;
      w_wr_en_next   = 1'b0;
      w_wr_addr_next = r_wr_addr;
      w_wr_data_next = r_wr_data;
      w_done_next    = 1'b0;
      w_loaded_next  = r_loaded;
      w_error_next   = r_error;
`ifdef CHECKSUM_EN
      w_csum_next    = r_csum;
`endif

      case (r_state)
         ST_IDLE, ST_ERR: begin
            if (w_sync) begin
               w_state_next  = ST_LEN_HI;
               w_loaded_next = 1'b0;
               w_error_next  = 1'b0;
            end
         end
         ST_LEN_HI: begin
            if (i_rx_valid) begin
               w_len_next[15:8] = i_rx_data;
               w_state_next     = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (i_rx_valid) begin
               w_len_next[7:0] = i_rx_data;
               if (w_len_bad) begin
                  w_state_next = ST_ERR;
                  w_error_next = 1'b1;
               end else begin
                  w_state_next = ST_DATA;
                  w_bcnt_next  = '0;
                  w_wcnt_next  = '0;
`ifdef CHECKSUM_EN
                  w_csum_next  = '0;
`endif
               end
            end
         end
         ST_DATA: begin
            if (i_rx_valid) begin
               w_shift_next = w_shift_in;
`ifdef CHECKSUM_EN
               w_csum_next  = r_csum ^ i_rx_data;
`endif
               if (r_bcnt == NB_BCNT'(BPW - 1)) begin
                  w_bcnt_next    = '0;
                  w_wr_en_next   = 1'b1;
                  w_wr_addr_next = r_wcnt[NB_ADDR-1:0];
                  w_wr_data_next = w_word;
                  w_wcnt_next    = r_wcnt + NB_WCNT'(1);
                  if (w_last_word) begin
`ifdef CHECKSUM_EN
                     w_state_next  = ST_CHECK;
`else
                     w_state_next  = ST_IDLE;
                     w_done_next   = 1'b1;
                     w_loaded_next = 1'b1;
`endif
                  end
               end else begin
                  w_bcnt_next = r_bcnt + NB_BCNT'(1);
               end
            end
         end
`ifdef CHECKSUM_EN
         // Writes already issued stay in memory even when the checksum disagrees.
         ST_CHECK: begin
            if (i_rx_valid) begin
               if (i_rx_data == r_csum) begin
                  w_state_next  = ST_IDLE;
                  w_done_next   = 1'b1;
                  w_loaded_next = 1'b1;
               end else begin
                  w_state_next  = ST_ERR;
                  w_error_next  = 1'b1;
               end
            end
         end
`endif
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign o_wr_en   = r_wr_en;
   assign o_wr_addr = r_wr_addr;
   assign o_wr_data = r_wr_data;
   assign o_done    = r_done;
   assign o_loaded  = r_loaded;
   assign o_error   = r_error;
   assign o_busy    = (r_state != ST_IDLE) && (r_state != ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader (default build, CHECKSUM_EN undefined): frame-level
// model queues expected writes, a negedge monitor pops and compares every write strobe.
module tb_program_loader;
   localparam int NB_INSTRUCTION = 16;
   localparam int NB_ADDR        = 10;
   localparam int ROM_DEPTH      = 1024;
   localparam int BPW            = NB_INSTRUCTION / 8;

   logic                      i_clock = 1'b0;
   logic                      i_reset;
   logic [7:0]                i_rx_data;
   logic                      i_rx_valid;
   logic                      o_wr_en;
   logic [NB_ADDR-1:0]        o_wr_addr;
   logic [NB_INSTRUCTION-1:0] o_wr_data;
   logic                      o_busy;
   logic                      o_done;
   logic                      o_loaded;
   logic                      o_error;

   typedef struct {
      int          addr;
      logic [15:0] data;
      bit          last;
      longint      cycle;
   } exp_t;

   exp_t       expQ[$];
   exp_t       monE;
   logic [7:0] payload[$];
   logic [7:0] garbage[$];
   int         totalCount = 0;
   int         badCount   = 0;
   longint     cycleCount = 0;
   bit         expLoaded  = 1'b0;
   bit         expError   = 1'b0;

   program_loader #(
      .NB_INSTRUCTION(NB_INSTRUCTION),
      .NB_ADDR       (NB_ADDR),
      .ROM_DEPTH     (ROM_DEPTH),
      .SYNC_BYTE     (8'hA5)
   ) dut (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_rx_data (i_rx_data),
      .i_rx_valid(i_rx_valid),
      .o_wr_en   (o_wr_en),
      .o_wr_addr (o_wr_addr),
      .o_wr_data (o_wr_data),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_loaded  (o_loaded),
      .o_error   (o_error)
   );

   always #5 i_clock = ~i_clock;

   always @(posedge i_clock) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Each write strobe must match the oldest queued expectation, including its cycle.
   always @(negedge i_clock) begin
      if (i_reset) begin
         if (o_wr_en) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_write_addr", 32'(o_wr_addr), 32'hFFFF_FFFF);
            end else begin
               monE = expQ.pop_front();
               checkOutput("wr_addr",   32'(o_wr_addr), 32'(monE.addr));
               checkOutput("wr_data",   32'(o_wr_data), 32'(monE.data));
               checkOutput("wr_cycle",  32'(cycleCount), 32'(monE.cycle));
               checkOutput("wr_done",   32'(o_done),   32'(monE.last));
               checkOutput("wr_loaded", 32'(o_loaded), 32'(monE.last));
               checkOutput("wr_busy",   32'(o_busy),   32'(!monE.last));
            end
         end else begin
            checkOutput("done_without_write", 32'(o_done), 32'd0);
         end
      end
   end

   function automatic logic [7:0] nonSync();
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'hA5);
      return b;
   endfunction

   task automatic sendByte(input logic [7:0] b, input bit gaps);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      @(posedge i_clock); #1;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'($urandom);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge i_clock); #1;
         end
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_wr_en"},   32'(o_wr_en),   32'd0);
      checkOutput({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
      checkOutput({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
      checkOutput({tag, "_busy"},    32'(o_busy),    32'd0);
      checkOutput({tag, "_done"},    32'(o_done),    32'd0);
      checkOutput({tag, "_loaded"},  32'(o_loaded),  32'd0);
      checkOutput({tag, "_error"},   32'(o_error),   32'd0);
   endtask

   // Frame-level model: a legal length yields one write per BPW payload bytes, addresses 0..N-1.
   task automatic applyStimulus(input int nWords, input int abortAt, input bit gaps);
      bit   valid;
      exp_t e;
      valid = (nWords >= 1) && (nWords <= ROM_DEPTH);
      foreach (garbage[i]) sendByte(garbage[i], gaps);
      sendByte(8'hA5, gaps);
      sendByte(8'(nWords >> 8), gaps);
      sendByte(8'(nWords), gaps);
      for (int i = 0; i < payload.size(); i++) begin
         if (abortAt >= 0 && i == abortAt) break;
         if (valid && (i % BPW) == BPW - 1) begin
            e.addr  = i / BPW;
            e.data  = {payload[i-1], payload[i]};
            e.last  = (i / BPW) == nWords - 1;
            e.cycle = cycleCount + 1;
            expQ.push_back(e);
         end
         sendByte(payload[i], gaps);
      end
      if (abortAt >= 0) begin
         @(posedge i_clock); #2;
         i_reset = 1'b0;
         #1;
         checkResetOutputs("midframe_reset");
         checkOutput("queue_after_reset", 32'(expQ.size()), 32'd0);
         expQ.delete();
         expLoaded = 1'b0;
         expError  = 1'b0;
         #2;
         i_reset = 1'b1;
         @(posedge i_clock); #1;
      end else begin
         expLoaded = valid;
         expError  = !valid;
         repeat (3) @(posedge i_clock);
         #1;
         checkOutput("error_level",    32'(o_error),  32'(expError));
         checkOutput("loaded_level",   32'(o_loaded), 32'(expLoaded));
         checkOutput("busy_after",     32'(o_busy),   32'd0);
         checkOutput("pending_writes", 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      i_reset    = 1'b0;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
      repeat (3) @(posedge i_clock);
      #1;
      checkResetOutputs("reset");
      i_reset = 1'b1;
      @(posedge i_clock); #1;

      $display("[TB] two-word frame");
      garbage = {};
      payload = {8'h12, 8'h34, 8'hAB, 8'hCD};
      applyStimulus(2, -1, 1'b0);

      $display("[TB] idle garbage then one-word frame");
      garbage = {8'h00, 8'hFF, 8'h5A};
      payload = {8'hBE, 8'hEF};
      applyStimulus(1, -1, 1'b0);
      garbage = {};

      $display("[TB] zero length then recovery");
      payload = {};
      applyStimulus(0, -1, 1'b0);
      payload = {8'h00, 8'h01};
      applyStimulus(1, -1, 1'b0);

      $display("[TB] oversize length");
      payload = {8'h11, 8'h22, 8'h33};
      applyStimulus(1025, -1, 1'b0);

      $display("[TB] full-depth frame");
      payload = {};
      for (int i = 0; i < ROM_DEPTH * BPW; i++) payload.push_back(8'($urandom));
      applyStimulus(ROM_DEPTH, -1, 1'b0);

      $display("[TB] reset during data, then clean frame");
      payload = {};
      for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
      applyStimulus(4, 3, 1'b0);
      payload = {8'hA5, 8'h5A, 8'h0F, 8'hF0};
      applyStimulus(2, -1, 1'b0);

      $display("[TB] randomized frames");
      for (int f = 0; f < 30; f++) begin
         garbage = {};
         repeat ($urandom_range(0, 3)) garbage.push_back(nonSync());
         payload = {};
         if ($urandom_range(0, 4) == 0) begin
            n = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1025, 65535));
            repeat ($urandom_range(0, 4)) payload.push_back(nonSync());
            applyStimulus(n, -1, 1'b1);
         end else begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n * BPW; i++) payload.push_back(8'($urandom));
            if ($urandom_range(0, 5) == 0)
               applyStimulus(n, int'($urandom_range(0, n * BPW - 1)), 1'b1);
            else
               applyStimulus(n, -1, 1'b1);
         end
      end

      repeat (2) @(posedge i_clock);
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
